// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon Says round sequencer.
package simon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INTRO,
    ST_SHOW_ON,
    ST_SHOW_OFF,
    ST_INPUT,
    ST_WIN,
    ST_LOSE,
    ST_DONE
  } state_t;

  localparam logic [1:0] DISP_COUNT  = 2'd0;
  localparam logic [1:0] DISP_LEVEL  = 2'd1;
  localparam logic [1:0] DISP_RESULT = 2'd2;
  localparam logic [1:0] DISP_BLANK  = 2'd3;

  // Polynomial x^8 + x^6 + x^5 + x^4 + 1, feedback taken from bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic [7:0] lfsr_advance(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

  function automatic logic [3:0] sym_onehot(input logic [1:0] s);
    return 4'b0001 << s;
  endfunction

  function automatic logic [1:0] disp_of(input state_t s);
    logic [1:0] d;
    d = DISP_LEVEL;
    case (s)
      ST_IDLE:  d = DISP_BLANK;
      ST_INTRO: d = DISP_COUNT;
      ST_DONE:  d = DISP_RESULT;
      default:  d = DISP_LEVEL;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/simon_game_ctrl_if.sv
// Player/timebase inputs and display/LED outputs of the round sequencer.
interface simon_game_ctrl_if;
  logic       tick;
  logic       start;
  logic [3:0] btn;
  logic       intro_start;
  logic       intro_inc;
  logic [3:0] led;
  logic [1:0] disp_sel;
  logic [4:0] level;
  logic [4:0] score;
  logic       game_over;
  logic       won;

  modport master (
    output tick, start, btn,
    input  intro_start, intro_inc, led, disp_sel, level, score, game_over, won
  );

  modport slave (
    input  tick, start, btn,
    output intro_start, intro_inc, led, disp_sel, level, score, game_over, won
  );
endinterface

// File: rtl/simon_lfsr.sv
// 8-bit Fibonacci LFSR that generates the colour pattern; load wins over step.
module simon_lfsr
  import simon_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       step,
  output logic [7:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= 8'h00;
    end else if (load) begin
      q <= seed;
    end else if (step) begin
      q <= lfsr_advance(q);
    end
  end

endmodule

// File: rtl/simon_game_ctrl.sv
// Simon Says round sequencer: countdown, pattern playback, player check, result.
//  state    | meaning
//  IDLE     | after reset, waiting for start
//  INTRO    | ready/set/go countdown pulses
//  SHOW_ON  | pattern symbol lit
//  SHOW_OFF | dark gap after a symbol
//  INPUT    | checking player presses against the pattern
//  WIN      | round cleared, waiting one tick before the next round
//  LOSE     | wrong press or timeout
//  DONE     | result shown, waiting for a new start
module simon_game_ctrl
  import simon_pkg::*;
#(
  parameter int         MAX_LEVEL      = 16,
  parameter int         INTRO_STEPS    = 3,
  parameter int         SHOW_ON_TICKS  = 2,
  parameter int         SHOW_OFF_TICKS = 1,
  parameter int         TIMEOUT_TICKS  = 8,
  parameter logic [7:0] SEED           = 8'hA5
) (
  input logic              clk,
  input logic              reset,
  simon_game_ctrl_if.slave bus
);

  localparam logic [4:0] LVL_MAX = 5'(MAX_LEVEL);
  localparam logic [7:0] T_INTRO = 8'(INTRO_STEPS);
  localparam logic [7:0] T_ON    = 8'(SHOW_ON_TICKS);
  localparam logic [7:0] T_OFF   = 8'(SHOW_OFF_TICKS);
  localparam logic [7:0] T_WAIT  = 8'(TIMEOUT_TICKS);

  state_t     state, state_n;
  logic [7:0] timer, timer_n;
  logic [4:0] idx, idx_n;
  logic [4:0] level_q, level_n;
  logic [4:0] score_q, score_n;
  logic       won_q, won_n;
  logic [7:0] free_cnt;
  logic [7:0] seed_q;
  logic [7:0] seed_mix;
  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;
  logic       lfsr_load;
  logic       lfsr_step;
  logic       seed_cap;
  logic       inc_n;
  logic       last_sym;
  logic       btn_hit;

  logic       intro_start_q;
  logic       intro_inc_q;
  logic [3:0] led_q;
  logic [1:0] disp_q;
  logic       over_q;

  simon_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (lfsr_load),
    .seed  (seed_q),
    .step  (lfsr_step),
    .q     (lfsr_q)
  );

  assign seed_mix = free_cnt ^ SEED;
  assign last_sym = (idx + 5'd1) == level_q;
  assign btn_hit  = bus.btn == sym_onehot(lfsr_q[1:0]);

  // Next LFSR value, so the registered LED shows the symbol of the state being entered.
  always_comb begin
    lfsr_d = lfsr_q;
    if (lfsr_load) begin
      lfsr_d = seed_q;
    end else if (lfsr_step) begin
      lfsr_d = lfsr_advance(lfsr_q);
    end
  end

  always_comb begin
    state_n   = state;
    timer_n   = timer;
    idx_n     = idx;
    level_n   = level_q;
    score_n   = score_q;
    won_n     = won_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    seed_cap  = 1'b0;
    inc_n     = 1'b0;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_n  = ST_INTRO;
          timer_n  = T_INTRO;
          level_n  = 5'd1;
          score_n  = 5'd0;
          won_n    = 1'b0;
          seed_cap = 1'b1;
        end
      end

      ST_INTRO: begin
        if (bus.tick) begin
          if (timer == 8'd0) begin
            state_n   = ST_SHOW_ON;
            timer_n   = T_ON;
            idx_n     = 5'd0;
            lfsr_load = 1'b1;
          end else begin
            timer_n = timer - 8'd1;
            inc_n   = 1'b1;
          end
        end
      end

      ST_SHOW_ON: begin
        if (bus.tick) begin
          if (timer <= 8'd1) begin
            state_n = ST_SHOW_OFF;
            timer_n = T_OFF;
          end else begin
            timer_n = timer - 8'd1;
          end
        end
      end

      ST_SHOW_OFF: begin
        if (bus.tick) begin
          if (timer <= 8'd1) begin
            lfsr_step = 1'b1;
            if (last_sym) begin
              state_n   = ST_INPUT;
              idx_n     = 5'd0;
              timer_n   = T_WAIT;
              lfsr_load = 1'b1;
            end else begin
              state_n = ST_SHOW_ON;
              idx_n   = idx + 5'd1;
              timer_n = T_ON;
            end
          end else begin
            timer_n = timer - 8'd1;
          end
        end
      end

      ST_INPUT: begin
        if (bus.btn != 4'd0) begin
          if (!btn_hit) begin
            state_n = ST_LOSE;
          end else if (last_sym) begin
            state_n = ST_WIN;
            score_n = (score_q < LVL_MAX) ? score_q + 5'd1 : score_q;
            level_n = (level_q < LVL_MAX) ? level_q + 5'd1 : level_q;
          end else begin
            idx_n     = idx + 5'd1;
            lfsr_step = 1'b1;
            timer_n   = T_WAIT;
          end
        end else if (bus.tick) begin
          if (timer <= 8'd1) begin
            state_n = ST_LOSE;
          end else begin
            timer_n = timer - 8'd1;
          end
        end
      end

      // score was bumped on entry, so it equals MAX_LEVEL only after the final round
      ST_WIN: begin
        if (score_q == LVL_MAX) begin
          state_n = ST_DONE;
          won_n   = 1'b1;
        end else if (bus.tick) begin
          state_n   = ST_SHOW_ON;
          timer_n   = T_ON;
          idx_n     = 5'd0;
          lfsr_load = 1'b1;
        end
      end

      ST_LOSE: begin
        state_n = ST_DONE;
        won_n   = 1'b0;
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      timer    <= 8'd0;
      idx      <= 5'd0;
      level_q  <= 5'd0;
      score_q  <= 5'd0;
      won_q    <= 1'b0;
      free_cnt <= 8'd0;
      seed_q   <= SEED;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      idx      <= idx_n;
      level_q  <= level_n;
      score_q  <= score_n;
      won_q    <= won_n;
      free_cnt <= free_cnt + 8'd1;
      if (seed_cap) begin
        seed_q <= (seed_mix == 8'd0) ? SEED : seed_mix;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      intro_start_q <= 1'b0;
      intro_inc_q   <= 1'b0;
      led_q         <= 4'd0;
      disp_q        <= DISP_BLANK;
      over_q        <= 1'b0;
    end else begin
      intro_start_q <= state_n == ST_INTRO;
      intro_inc_q   <= inc_n;
      led_q         <= (state_n == ST_SHOW_ON) ? sym_onehot(lfsr_d[1:0]) : 4'd0;
      disp_q        <= disp_of(state_n);
      over_q        <= state_n == ST_DONE;
    end
  end

  assign bus.intro_start = intro_start_q;
  assign bus.intro_inc   = intro_inc_q;
  assign bus.led         = led_q;
  assign bus.disp_sel    = disp_q;
  assign bus.level       = level_q;
  assign bus.score       = score_q;
  assign bus.game_over   = over_q;
  assign bus.won         = won_q;

endmodule
